// File: rtl/ps2_key_tracker_pkg.sv
// rtl/ps2_key_tracker_pkg.sv - shared PS/2 constants, parser states and sizing helper
// Purpose: prefix bytes, default watched-key table ({ext, code} per key) and
// parser state encoding used by ps2_key_tracker. No ports.
package ps2_key_tracker_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT = 9'h174;
  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_SPACE = 9'h029;

  // Index 0 sits in the least significant 9 bits.
  localparam logic [53:0] DEFAULT_KEY_CODES =
    {KEY_SPACE, KEY_ENTER, KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  // Key index width; a single watched key still needs one index bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous event FIFO with count and sticky overflow
// Ports:
//   i_clk, i_rst_n (async active-low), i_clear (sync flush incl. overflow)
//   i_push/i_data  : write request and payload
//   i_pop          : consumer accepts head (ignored while empty)
//   o_valid/o_data : head valid and head payload (zero while empty)
//   o_count        : occupied entries, o_overflow : sticky dropped-push flag
module ps2_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_push  = i_push && (!w_full || w_pop);
  assign w_drop  = i_push && w_full && !w_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 scan-code parser, watched-key state and event queue
// Ports:
//   CLOCK_50, resetn (async active-low)
//   received_data/received_data_en : byte stream from PS2_Controller
//   clear        : sync flush of parser, key state, FIFO and overflow
//   key_down     : held level per watched key
//   key_press    : one-cycle pulse per press, key_release : per release
//   ev_valid/ev_data/ev_ready : event FIFO head {is_break, key_idx}
//   ev_count     : FIFO occupancy, overflow : sticky dropped-event flag
module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int                    NUM_KEYS  = 6,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES = DEFAULT_KEY_CODES,
  parameter bit                    REPEAT_EN = 1'b0,
  parameter int                    DEPTH     = 8,
  parameter int                    TIMEOUT   = 50000
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic [7:0]                  received_data,
  input  logic                        received_data_en,
  input  logic                        clear,
  output logic [NUM_KEYS-1:0]         key_down,
  output logic [NUM_KEYS-1:0]         key_press,
  output logic [NUM_KEYS-1:0]         key_release,
  output logic                        ev_valid,
  output logic [idx_w(NUM_KEYS):0]    ev_data,
  input  logic                        ev_ready,
  output logic [$clog2(DEPTH+1)-1:0]  ev_count,
  output logic                        overflow
);

  localparam int IDX_W = idx_w(NUM_KEYS);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  parse_state_t r_state;
  parse_state_t w_next_state;
  logic [TO_W-1:0] r_idle_cnt;

  logic [NUM_KEYS-1:0] r_key_down;
  logic [NUM_KEYS-1:0] r_key_press;
  logic [NUM_KEYS-1:0] r_key_release;

  logic                w_timeout;
  logic                w_done;
  logic                w_brk;
  logic                w_ext;
  logic [8:0]          w_code;
  logic                w_match;
  logic [NUM_KEYS-1:0] w_match_oh;
  logic [IDX_W-1:0]    w_match_idx;
  logic                w_was_down;
  logic                w_push;

  // A partial prefix is abandoned after TIMEOUT strobe-free cycles.
  assign w_timeout = (r_state != ST_IDLE) && !received_data_en &&
                     (r_idle_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_brk        = 1'b0;
    w_ext        = 1'b0;
    if (clear) begin
      w_next_state = ST_IDLE;
    end else if (received_data_en) begin
      case (r_state)
        ST_IDLE: begin
          if (received_data == PS2_EXT)      w_next_state = ST_EXT;
          else if (received_data == PS2_BRK) w_next_state = ST_BRK;
          else                               w_done       = 1'b1;
        end
        ST_EXT: begin
          if (received_data == PS2_BRK) begin
            w_next_state = ST_EXT_BRK;
          end else if (received_data != PS2_EXT) begin
            w_done       = 1'b1;
            w_ext        = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_done       = 1'b1;
          w_brk        = 1'b1;
          w_next_state = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_done       = 1'b1;
          w_brk        = 1'b1;
          w_ext        = 1'b1;
          w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_next_state = ST_IDLE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_idle_cnt <= '0;
    end else if (clear || received_data_en || (r_state == ST_IDLE) || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end
  end

  // Scan upward and keep the first hit so duplicate codes resolve to the lowest index.
  always_comb begin
    w_code      = {w_ext, received_data};
    w_match     = 1'b0;
    w_match_oh  = '0;
    w_match_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!w_match && (KEY_CODES[9*i +: 9] == w_code)) begin
        w_match        = 1'b1;
        w_match_oh[i]  = 1'b1;
        w_match_idx    = IDX_W'(i);
      end
    end
  end

  assign w_was_down = |(r_key_down & w_match_oh);
  assign w_push     = w_done && w_match &&
                      (w_brk ? w_was_down : (!w_was_down || REPEAT_EN));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_key_down    <= '0;
      r_key_press   <= '0;
      r_key_release <= '0;
    end else begin
      r_key_press   <= '0;
      r_key_release <= '0;
      if (clear) begin
        r_key_down <= '0;
      end else if (w_push) begin
        if (w_brk) begin
          r_key_down    <= r_key_down & ~w_match_oh;
          r_key_release <= w_match_oh;
        end else begin
          r_key_down    <= r_key_down | w_match_oh;
          r_key_press   <= w_match_oh;
        end
      end
    end
  end

  assign key_down    = r_key_down;
  assign key_press   = r_key_press;
  assign key_release = r_key_release;

  ps2_event_fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .i_clk      (CLOCK_50),
    .i_rst_n    (resetn),
    .i_clear    (clear),
    .i_push     (w_push),
    .i_data     ({w_brk, w_match_idx}),
    .i_pop      (ev_ready),
    .o_valid    (ev_valid),
    .o_data     (ev_data),
    .o_count    (ev_count),
    .o_overflow (overflow)
  );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - scoreboard bench for ps2_key_tracker with REPEAT_EN 0 and 1
module tb_ps2_key_tracker;

  localparam int TO    = 200;
  localparam int DEPTH = 8;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       clear = 1'b0;
  logic       ev_ready = 1'b0;

  logic [5:0] kd0, kp0, kr0, kd1, kp1, kr1;
  logic       ev_valid0, ev_valid1, ovf0, ovf1;
  logic [3:0] ev_data0, ev_data1, cnt0, cnt1;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_key_tracker #(.TIMEOUT(TO)) dut0 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .received_data(received_data),
    .received_data_en(received_data_en), .clear(clear),
    .key_down(kd0), .key_press(kp0), .key_release(kr0),
    .ev_valid(ev_valid0), .ev_data(ev_data0), .ev_ready(ev_ready),
    .ev_count(cnt0), .overflow(ovf0)
  );

  ps2_key_tracker #(.REPEAT_EN(1'b1), .TIMEOUT(TO)) dut1 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .received_data(received_data),
    .received_data_en(received_data_en), .clear(clear),
    .key_down(kd1), .key_press(kp1), .key_release(kr1),
    .ev_valid(ev_valid1), .ev_data(ev_data1), .ev_ready(ev_ready),
    .ev_count(cnt1), .overflow(ovf1)
  );

  // Reference model: watched-key table, prefix flags, held keys, expected events.
  logic [8:0] codes [6] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A, 9'h029};
  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h29, 8'hAA, 8'hE1};
  bit         m_ext, m_brk;
  logic [5:0] held [2];
  logic [5:0] exp_press [2];
  logic [5:0] exp_rel [2];
  bit         exp_ovf [2];
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];
  int         checks = 0, errors = 0, mon_checks = 0, mon_errors = 0;
  bit         rand_ready = 1'b0;

  function automatic void push_ev(input int r, input logic [3:0] ev);
    int sz;
    sz = (r == 0) ? q0.size() : q1.size();
    if (sz < DEPTH || ev_ready) begin
      if (r == 0) q0.push_back(ev);
      else        q1.push_back(ev);
    end else begin
      exp_ovf[r] = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    m_ext = 1'b0;
    m_brk = 1'b0;
    for (int r = 0; r < 2; r++) begin
      held[r] = '0; exp_press[r] = '0; exp_rel[r] = '0; exp_ovf[r] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    for (int r = 0; r < 2; r++) begin
      exp_press[r] = '0; exp_rel[r] = '0;
    end
    if (b == 8'hE0 && !m_brk) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1'b1;
    end else begin
      k = -1;
      for (int i = 5; i >= 0; i--) if (codes[i] == {m_ext, b}) k = i;
      if (k >= 0) begin
        for (int r = 0; r < 2; r++) begin
          if (m_brk) begin
            if (held[r][k]) begin
              held[r][k] = 1'b0; exp_rel[r][k] = 1'b1; push_ev(r, {1'b1, 3'(k)});
            end
          end else if (!held[r][k] || r == 1) begin
            held[r][k] = 1'b1; exp_press[r][k] = 1'b1; push_ev(r, {1'b0, 3'(k)});
          end
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50); #1;
    if (rand_ready) ev_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_kd0"}, 32'(kd0), 0);  chk({tag, "_kd1"}, 32'(kd1), 0);
    chk({tag, "_kp0"}, 32'(kp0), 0);  chk({tag, "_kr0"}, 32'(kr0), 0);
    chk({tag, "_kp1"}, 32'(kp1), 0);  chk({tag, "_kr1"}, 32'(kr1), 0);
    chk({tag, "_valid0"}, 32'(ev_valid0), 0); chk({tag, "_valid1"}, 32'(ev_valid1), 0);
    chk({tag, "_data0"}, 32'(ev_data0), 0);   chk({tag, "_cnt0"}, 32'(cnt0), 0);
    chk({tag, "_cnt1"}, 32'(cnt1), 0);
    chk({tag, "_ovf0"}, 32'(ovf0), 0);        chk({tag, "_ovf1"}, 32'(ovf1), 0);
  endtask

  task automatic send(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    model_byte(b);
    tick();
    received_data_en = 1'b0;
    @(negedge CLOCK_50);
    chk("press0", 32'(kp0), 32'(exp_press[0]));  chk("release0", 32'(kr0), 32'(exp_rel[0]));
    chk("press1", 32'(kp1), 32'(exp_press[1]));  chk("release1", 32'(kr1), 32'(exp_rel[1]));
    chk("down0", 32'(kd0), 32'(held[0]));        chk("down1", 32'(kd1), 32'(held[1]));
    tick();
    @(negedge CLOCK_50);
    chk("pulse_end0", 32'({kp0, kr0}), 0);
    chk("pulse_end1", 32'({kp1, kr1}), 0);
    tick();
  endtask

  task automatic drain(input string tag);
    bit saved;
    saved      = rand_ready;
    rand_ready = 1'b0;
    ev_ready   = 1'b1;
    for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    repeat (2) tick();
    @(negedge CLOCK_50);
    chk({tag, "_q0_left"}, q0.size(), 0);
    chk({tag, "_q1_left"}, q1.size(), 0);
    chk({tag, "_cnt0"}, 32'(cnt0), 0);
    chk({tag, "_cnt1"}, 32'(cnt1), 0);
    rand_ready = saved;
    tick();
  endtask

  // Scoreboard monitor: compares each presented head against the expected queue.
  always @(negedge CLOCK_50) begin
    if (resetn && !clear) begin
      if (ev_valid0) begin
        mon_checks++;
        if (q0.size() == 0) begin
          mon_errors++;
          $display("FAIL ev0_unexpected got %h want none", ev_data0);
        end else begin
          if (ev_data0 !== q0[0]) begin
            mon_errors++;
            $display("FAIL ev0_data got %h want %h", ev_data0, q0[0]);
          end
          if (ev_ready) void'(q0.pop_front());
        end
      end
      if (ev_valid1) begin
        mon_checks++;
        if (q1.size() == 0) begin
          mon_errors++;
          $display("FAIL ev1_unexpected got %h want none", ev_data1);
        end else begin
          if (ev_data1 !== q1[0]) begin
            mon_errors++;
            $display("FAIL ev1_data got %h want %h", ev_data1, q1[0]);
          end
          if (ev_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    @(negedge CLOCK_50);
    check_reset("in_reset");
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check_reset("after_reset");
    tick();
    ev_ready = 1'b1;

    // Plain 75 ignored, E0 75 presses up, E0 F0 75 releases it.
    send(8'h75);
    chk("plain75_down", 32'(kd0), 0);
    send(8'hE0); send(8'h75);
    chk("up_down", 32'(kd0), 32'(6'b000001));
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_released", 32'(kd0), 0);
    drain("t_up");

    // Typematic enter: 2 events without repeat, 4 with repeat.
    ev_ready = 1'b0;
    send(8'h5A); send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A);
    @(negedge CLOCK_50);
    chk("rep_cnt0", 32'(cnt0), 2);
    chk("rep_cnt1", 32'(cnt1), 4);
    drain("t_rep");

    // Several keys held, released in a different order.
    send(8'hE0); send(8'h75); send(8'h29); send(8'hE0); send(8'h6B);
    chk("multi_down0", 32'(kd0), 32'(6'b100101));
    chk("multi_down1", 32'(kd1), 32'(6'b100101));
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h29);
    drain("t_multi");

    // Overflow: 10 events into a stalled FIFO, then push+pop while full.
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'h5A); send(8'hF0); send(8'h5A);
    end
    @(negedge CLOCK_50);
    chk("full_cnt0", 32'(cnt0), 8);   chk("full_ovf0", 32'(ovf0), 1);
    chk("full_cnt1", 32'(cnt1), 8);   chk("full_ovf1", 32'(ovf1), 1);
    tick();
    ev_ready         = 1'b1;
    received_data    = 8'h5A;
    received_data_en = 1'b1;
    model_byte(8'h5A);
    tick();
    received_data_en = 1'b0;
    ev_ready         = 1'b0;
    @(negedge CLOCK_50);
    chk("pushpop_cnt0", 32'(cnt0), 8);
    chk("pushpop_cnt1", 32'(cnt1), 8);
    tick();
    send(8'hF0); send(8'h5A);
    drain("t_ovf");
    chk("ovf_sticky0", 32'(ovf0), 1);

    // Timeout abandons a lone E0; 29 is then a plain space press.
    send(8'hE0);
    repeat (TO + 10) tick();
    m_ext = 1'b0;
    m_brk = 1'b0;
    send(8'h29);
    chk("timeout_down", 32'(kd0), 32'(6'b100000));
    send(8'hF0); send(8'h29);
    drain("t_timeout");

    // Clear with keys held, events queued and a partial prefix; clear beats a byte.
    ev_ready = 1'b0;
    send(8'h5A); send(8'h29); send(8'hE0);
    clear            = 1'b1;
    received_data    = 8'h75;
    received_data_en = 1'b1;
    model_reset();
    tick();
    clear            = 1'b0;
    received_data_en = 1'b0;
    @(negedge CLOCK_50);
    check_reset("clear");
    tick();
    ev_ready = 1'b1;
    send(8'h75);
    chk("after_clear_75", 32'(kd0), 0);
    send(8'h5A);

    // Reset mid-sequence after F0; next byte is a make from IDLE.
    send(8'hF0);
    resetn = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    check_reset("mid_reset");
    tick();
    resetn = 1'b1;
    tick();
    send(8'h5A);
    chk("after_reset_make", 32'(kd0), 32'(6'b010000));
    send(8'hF0); send(8'h5A);
    drain("t_reset");

    // Randomized byte stream with random consumer back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) send(pool[$urandom_range(0, 9)]);
    drain("t_random");
    chk("rand_ovf0", 32'(ovf0), 32'(exp_ovf[0]));
    chk("rand_ovf1", 32'(ovf1), 32'(exp_ovf[1]));

    checks += mon_checks;
    errors += mon_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
